// File: rtl/seg_display_pkg.sv
// Shared constants and types for the six-digit seven-segment scanner.
// Segment patterns are active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
package seg_display_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hFD;

   localparam logic [7:0] SEG_D0 = 8'h03;
   localparam logic [7:0] SEG_D1 = 8'h9F;
   localparam logic [7:0] SEG_D2 = 8'h25;
   localparam logic [7:0] SEG_D3 = 8'h0D;
   localparam logic [7:0] SEG_D4 = 8'h99;
   localparam logic [7:0] SEG_D5 = 8'h49;
   localparam logic [7:0] SEG_D6 = 8'h41;
   localparam logic [7:0] SEG_D7 = 8'h1F;
   localparam logic [7:0] SEG_D8 = 8'h01;
   localparam logic [7:0] SEG_D9 = 8'h09;

   typedef struct packed {
      logic [BCD_W-1:0] bcd;
      logic             ovf;
   } disp_t;

endpackage

// File: rtl/seg_display_scanner_decoder.sv
// Combinational BCD nibble to active-low segment pattern.
// Any non-decimal nibble renders as a dash.
module digit_seg_decoder
   import seg_display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [7:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_nibble)
         4'd0:    o_seg = SEG_D0;
         4'd1:    o_seg = SEG_D1;
         4'd2:    o_seg = SEG_D2;
         4'd3:    o_seg = SEG_D3;
         4'd4:    o_seg = SEG_D4;
         4'd5:    o_seg = SEG_D5;
         4'd6:    o_seg = SEG_D6;
         4'd7:    o_seg = SEG_D7;
         4'd8:    o_seg = SEG_D8;
         4'd9:    o_seg = SEG_D9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_display_scanner.sv
// Six-digit multiplexed 7-seg driver with tear-free frame-boundary update.
// Optional leading-zero blanking when SEG_LZB_EN is defined.
module seg_display_scanner
   import seg_display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [BCD_W-1:0] bcd_in,
   input  logic             bcd_valid,
   input  logic             ovf_in,
   output logic [7:0]       seg,
   output logic [5:0]       an,
   output logic             frame_done
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   logic [CW-1:0] r_slot_cnt;
   logic [2:0]    r_idx;
   disp_t         r_pend;
   logic          r_pend_flag;
   disp_t         r_disp;

   logic          w_slot_end;
   logic          w_frame_end;
   logic          w_active;
   logic          w_blank;
   logic [3:0]    w_digits [NUM_DIGITS];
   logic [3:0]    w_nibble;
   logic [7:0]    w_dec;
   logic [7:0]    w_pat;

   assign w_slot_end  = (r_slot_cnt == CW'(DIGIT_CYCLES - 1));
   assign w_frame_end = w_slot_end && (r_idx == 3'(NUM_DIGITS - 1));
   assign w_active    = (r_slot_cnt >= CW'(BLANK_CYCLES));

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_digits[i] = r_disp.bcd[BCD_W-1-4*i -: 4];
      end
   end

   assign w_nibble = w_digits[r_idx];

`ifdef SEG_LZB_EN
   logic [NUM_DIGITS-1:0] w_lz;

   // w_lz[i]: digit i and every more-significant digit are zero
   always_comb begin
      w_lz    = '0;
      w_lz[0] = (w_digits[0] == 4'd0);
      for (int i = 1; i < NUM_DIGITS - 1; i++) begin
         w_lz[i] = w_lz[i-1] && (w_digits[i] == 4'd0);
      end
   end

   assign w_blank = w_lz[r_idx];
`else
   assign w_blank = 1'b0;
`endif

   digit_seg_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_dec)
   );

   // Blanked digits are always zero, so they never collide with a dash
   always_comb begin
      w_pat = w_dec;
      if (r_disp.ovf) begin
         w_pat = SEG_DASH;
      end else if (w_blank) begin
         w_pat = SEG_BLANK;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot_cnt  <= '0;
         r_idx       <= '0;
         r_pend      <= '0;
         r_pend_flag <= 1'b0;
         r_disp      <= '0;
         seg         <= SEG_BLANK;
         an          <= 6'h3F;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= w_frame_end;

         if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_idx      <= w_frame_end ? 3'd0 : r_idx + 3'd1;
         end else begin
            r_slot_cnt <= r_slot_cnt + CW'(1);
         end

         if (w_frame_end && r_pend_flag) begin
            r_disp <= r_pend;
         end

         // A strobe on the boundary edge re-arms the shadow after transfer
         if (w_frame_end) begin
            r_pend_flag <= 1'b0;
         end
         if (bcd_valid) begin
            r_pend.bcd  <= bcd_in;
            r_pend.ovf  <= ovf_in;
            r_pend_flag <= 1'b1;
         end

         if (w_active) begin
            an  <= ~(6'b1 << r_idx);
            seg <= w_pat;
         end else begin
            an  <= 6'h3F;
            seg <= SEG_BLANK;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomized self-checking bench for seg_display_scanner.
// Reference model predicts outputs from the edge count since reset.
module tb_seg_display_scanner;

   localparam int DC = 8;
   localparam int BC = 2;
   localparam int FR = 6 * DC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] bcd_in = '0;
   logic        bcd_valid = 1'b0;
   logic        ovf_in = 1'b0;
   logic [7:0]  seg;
   logic [5:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   int          n;
   logic [23:0] m_disp;
   logic        m_dovf;
   logic [23:0] m_pend;
   logic        m_povf;
   logic        m_pflag;

   logic [7:0] dec_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

   seg_display_scanner #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bcd_in     (bcd_in),
      .bcd_valid  (bcd_valid),
      .ovf_in     (ovf_in),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s n=%0d got %h expected %h", tag, n, got, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [23:0] d,
                                      input logic o, input int i);
      logic [3:0] nib;
      nib = d[23-4*i -: 4];
      if (o) return 8'hFD;
      if (nib > 4'd9) return 8'hFD;
`ifdef SEG_LZB_EN
      if (i < 5 && (d >> (4 * (5 - i))) == 24'd0) return 8'hFF;
`endif
      return dec_tab[nib];
   endfunction

   task automatic model_clear();
      n = 0;
      m_disp = '0;
      m_dovf = 1'b0;
      m_pend = '0;
      m_povf = 1'b0;
      m_pflag = 1'b0;
   endtask

   task automatic step(input logic v, input logic [23:0] b,
                       input logic o);
      int p, slot, dig;
      logic [7:0] e_seg;
      logic [5:0] e_an;
      logic       e_fd;
      bcd_valid = v;
      bcd_in = b;
      ovf_in = o;
      @(posedge clk);
      n++;
      p = n - 1;
      slot = p % DC;
      dig = (p / DC) % 6;
      if (slot < BC) begin
         e_an = 6'h3F;
         e_seg = 8'hFF;
      end else begin
         e_an = ~(6'b1 << dig);
         e_seg = pat(m_disp, m_dovf, dig);
      end
      e_fd = (n % FR == 0);
      if (e_fd) begin
         if (m_pflag) begin
            m_disp = m_pend;
            m_dovf = m_povf;
         end
         m_pflag = 1'b0;
      end
      if (v) begin
         m_pend = b;
         m_povf = o;
         m_pflag = 1'b1;
      end
      #1;
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      bcd_valid = 1'b0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 24'h0, 1'b0);
   endtask

   task automatic run_to(input int m);
      int guard = 0;
      while (n % FR != m && guard < 2 * FR) begin
         step(1'b0, 24'h0, 1'b0);
         guard++;
      end
   endtask

   function automatic logic [23:0] rand_bcd();
      logic [23:0] d;
      int lz;
      d = '0;
      lz = $urandom_range(0, 6);
      for (int i = 0; i < 6; i++) begin
         if (i >= lz) d[23-4*i -: 4] = 4'($urandom_range(0, 11));
      end
      return d;
   endfunction

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_fd", 32'(frame_done), 32'h0);
      reset = 1'b0;

      idle(FR);

      idle($urandom_range(3, 30));
      step(1'b1, 24'h001234, 1'b0);
      run_to(0);
      idle(2 * FR);

      idle($urandom_range(1, 40));
      step(1'b1, 24'h000012, 1'b1);
      run_to(0);
      idle(FR);

      run_to(0);
      idle($urandom_range(1, 10));
      step(1'b1, 24'h111111, 1'b0);
      idle($urandom_range(1, 10));
      step(1'b1, 24'h222222, 1'b0);
      run_to(FR - 1);
      step(1'b1, 24'h333333, 1'b0);
      idle(2 * FR);

      step(1'b1, 24'h0A0000, 1'b0);
      run_to(0);
      idle(FR);

      for (int i = 0; i < 8 * FR; i++) begin
         if ($urandom_range(0, 19) == 0)
            step(1'b1, rand_bcd(), ($urandom_range(0, 7) == 0));
         else
            step(1'b0, 24'h0, 1'b0);
      end
      run_to(0);
      idle(FR);

      step(1'b1, 24'h987654, 1'b0);
      idle($urandom_range(3, 20));
      #3;
      reset = 1'b1;
      #1;
      chk("async_seg", 32'(seg), 32'hFF);
      chk("async_an", 32'(an), 32'h3F);
      chk("async_fd", 32'(frame_done), 32'h0);
      @(posedge clk);
      #1;
      chk("hold_seg", 32'(seg), 32'hFF);
      chk("hold_an", 32'(an), 32'h3F);
      reset = 1'b0;
      model_clear();
      idle(3 * FR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
